// File: rtl/switch_sequencer.sv
// switch_sequencer: queues (setting word, dwell) entries and plays them onto
// the shared decoder/PWM datapath. For each entry: launch a decoder run, wait
// for done (bounded by DEC_TIMEOUT), then hold pwm_en for the programmed dwell
// counted in 1 MHz ticks.
module switch_sequencer #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned W_WIDTH     = 13,
  parameter int unsigned DUR_WIDTH   = 16,
  parameter int unsigned DEC_TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     abort,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [W_WIDTH-1:0]       wr_W,
  input  logic [DUR_WIDTH-1:0]     wr_dur,
  input  logic                     tick_1MHz,
  output logic                     dec_start,
  output logic [W_WIDTH-1:0]       dec_W,
  input  logic                     dec_done,
  output logic                     pwm_en,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     timeout_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(DEC_TIMEOUT) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_RUN
  } state_e;

  state_e                 state_q, state_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic [DUR_WIDTH-1:0]   active_dur_q, active_dur_d;
  logic [W_WIDTH-1:0]     dec_w_q, dec_w_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic [DUR_WIDTH-1:0]   tick_cnt_q, tick_cnt_d;
  logic                   pwm_en_q, pwm_en_d;
  logic                   tmo_err_q, tmo_err_d;

  logic [W_WIDTH-1:0]     mem_w   [DEPTH];
  logic [DUR_WIDTH-1:0]   mem_dur [DEPTH];

  logic push;
  logic pop;

  assign wr_ready    = (count_q < CW'(DEPTH)) && !abort;
  assign push        = wr_valid && wr_ready;
  assign pop         = (state_q == S_LOAD);
  assign dec_start   = (state_q == S_LOAD);
  // The head word is shown directly during LOAD so dec_W is already valid
  // in the dec_start cycle; afterwards the registered copy holds it.
  assign dec_W       = (state_q == S_LOAD) ? mem_w[rd_ptr_q] : dec_w_q;
  assign pwm_en      = pwm_en_q;
  assign busy        = (state_q != S_IDLE);
  assign fifo_count  = count_q;
  assign timeout_err = tmo_err_q;

  // Queue storage write port (contents need no reset; count qualifies them)
  always_ff @(posedge clk) begin
    if (push) begin
      mem_w[wr_ptr_q]   <= wr_W;
      mem_dur[wr_ptr_q] <= wr_dur;
    end
  end

  // Next-state logic for sequencer FSM, queue pointers and counters
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    active_dur_d = active_dur_q;
    dec_w_d      = dec_w_q;
    tmo_d        = tmo_q;
    tick_cnt_d   = tick_cnt_q;
    pwm_en_d     = (state_q == S_RUN) && en;
    tmo_err_d    = tmo_err_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (en && (count_q != '0)) state_d = S_LOAD;
      end
      S_LOAD: begin
        active_dur_d = mem_dur[rd_ptr_q];
        dec_w_d      = mem_w[rd_ptr_q];
        tmo_d        = '0;
        state_d      = S_WAIT;
      end
      S_WAIT: begin
        if (dec_done) begin
          if (active_dur_q == '0) begin
            state_d = S_IDLE;
          end else begin
            state_d    = S_RUN;
            tick_cnt_d = '0;
          end
        end else if (tmo_q == TW'(DEC_TIMEOUT - 2)) begin
          // Counter would reach DEC_TIMEOUT-1 on this cycle: give up on the entry
          tmo_err_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_RUN: begin
        if (tick_1MHz && en) begin
          if (tick_cnt_q == active_dur_q - DUR_WIDTH'(1)) begin
            state_d = (count_q != '0) ? S_LOAD : S_IDLE;
          end else begin
            tick_cnt_d = tick_cnt_q + DUR_WIDTH'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d    = S_IDLE;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      tmo_d      = '0;
      tick_cnt_d = '0;
      pwm_en_d   = 1'b0;
      tmo_err_d  = 1'b0;
    end
  end

  // State and counter registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      active_dur_q <= '0;
      dec_w_q      <= '0;
      tmo_q        <= '0;
      tick_cnt_q   <= '0;
      pwm_en_q     <= 1'b0;
      tmo_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      active_dur_q <= active_dur_d;
      dec_w_q      <= dec_w_d;
      tmo_q        <= tmo_d;
      tick_cnt_q   <= tick_cnt_d;
      pwm_en_q     <= pwm_en_d;
      tmo_err_q    <= tmo_err_d;
    end
  end

endmodule

// File: tb/tb_switch_sequencer.sv
// Directed self-checking bench for switch_sequencer (default parameters).
module tb_switch_sequencer;

  localparam int unsigned DEPTH       = 4;
  localparam int unsigned W_WIDTH     = 13;
  localparam int unsigned DUR_WIDTH   = 16;
  localparam int unsigned DEC_TIMEOUT = 64;

  logic                   clk;
  logic                   reset;
  logic                   en;
  logic                   abort;
  logic                   wr_valid;
  logic                   wr_ready;
  logic [W_WIDTH-1:0]     wr_W;
  logic [DUR_WIDTH-1:0]   wr_dur;
  logic                   tick_1MHz;
  logic                   dec_start;
  logic [W_WIDTH-1:0]     dec_W;
  logic                   dec_done;
  logic                   pwm_en;
  logic                   busy;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   timeout_err;

  int unsigned n_checks;
  int unsigned n_errors;

  switch_sequencer #(
    .DEPTH      (DEPTH),
    .W_WIDTH    (W_WIDTH),
    .DUR_WIDTH  (DUR_WIDTH),
    .DEC_TIMEOUT(DEC_TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .abort      (abort),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_W       (wr_W),
    .wr_dur     (wr_dur),
    .tick_1MHz  (tick_1MHz),
    .dec_start  (dec_start),
    .dec_W      (dec_W),
    .dec_done   (dec_done),
    .pwm_en     (pwm_en),
    .busy       (busy),
    .fifo_count (fifo_count),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Advance one clock; inputs set afterwards apply to the next edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    tick_1MHz = 1'b1;
    step();
    tick_1MHz = 1'b0;
  endtask

  task automatic push(input logic [W_WIDTH-1:0] w, input logic [DUR_WIDTH-1:0] d);
    wr_valid = 1'b1;
    wr_W     = w;
    wr_dur   = d;
    step();
    wr_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic bad;
    n_checks  = 0;
    n_errors  = 0;
    reset     = 1'b0;
    en        = 1'b0;
    abort     = 1'b0;
    wr_valid  = 1'b0;
    wr_W      = '0;
    wr_dur    = '0;
    tick_1MHz = 1'b0;
    dec_done  = 1'b0;

    // Reset values
    #12;
    check("rst_busy", busy, 0);
    check("rst_ready", wr_ready, 1);
    check("rst_count", fifo_count, 0);
    check("rst_decW", dec_W, 0);
    check("rst_start", dec_start, 0);
    check("rst_pwm", pwm_en, 0);
    check("rst_err", timeout_err, 0);
    reset = 1'b1;
    step();

    // Single entry, done 5 cycles after dec_start, dwell 3
    push(13'h0A5, 16'd3);
    check("t1_count", fifo_count, 1);
    en = 1'b1;
    step();
    check("t1_start", dec_start, 1);
    check("t1_decW", dec_W, 13'h0A5);
    step();
    check("t1_start_pulse", dec_start, 0);
    check("t1_count0", fifo_count, 0);
    check("t1_busy", busy, 1);
    step(); step(); step();
    check("t1_decW_hold", dec_W, 13'h0A5);
    dec_done = 1'b1;
    step();
    dec_done = 1'b0;
    check("t1_pwm_enter", pwm_en, 0);
    step();
    check("t1_pwm_on", pwm_en, 1);
    tick(); tick();
    check("t1_pwm_2tick", pwm_en, 1);
    check("t1_busy_2tick", busy, 1);
    tick();
    check("t1_idle", busy, 0);
    check("t1_pwm_lag", pwm_en, 1);
    step();
    check("t1_pwm_off", pwm_en, 0);

    // Back-to-back entries, dwell 2 each
    en = 1'b0;
    push(13'h111, 16'd2);
    push(13'h222, 16'd2);
    check("t2_count2", fifo_count, 2);
    en = 1'b1;
    step();
    check("t2_start1", dec_start, 1);
    check("t2_decW1", dec_W, 13'h111);
    step();
    check("t2_count1", fifo_count, 1);
    dec_done = 1'b1;
    step();
    dec_done = 1'b0;
    step();
    tick();
    tick();
    check("t2_start2", dec_start, 1);
    check("t2_decW2", dec_W, 13'h222);
    check("t2_busy", busy, 1);
    step();
    check("t2_count0", fifo_count, 0);
    dec_done = 1'b1;
    step();
    dec_done = 1'b0;
    tick();
    tick();
    check("t2_idle", busy, 0);
    step();

    // Full queue: 5 offers, only 4 accepted; drain checks order across wrap
    en       = 1'b0;
    wr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_W   = 13'(13'h100 + i);
      wr_dur = 16'd1;
      check($sformatf("t3_ready%0d", i), wr_ready, (i < 4) ? 1 : 0);
      step();
    end
    wr_valid = 1'b0;
    check("t3_full", fifo_count, 4);
    en = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t3_start%0d", i), dec_start, 1);
      check($sformatf("t3_decW%0d", i), dec_W, 32'h100 + i);
      step();
      dec_done = 1'b1;
      step();
      dec_done = 1'b0;
      tick();
    end
    check("t3_idle", busy, 0);
    check("t3_empty", fifo_count, 0);
    step();

    // Decoder timeout, then a normal launch with the flag still set
    en = 1'b0;
    push(13'h0F0, 16'd1);
    push(13'h0F1, 16'd1);
    en = 1'b1;
    step();
    check("t4_start", dec_start, 1);
    bad = 1'b0;
    for (int c = 1; c < DEC_TIMEOUT - 1; c++) begin
      step();
      if (pwm_en || !busy) bad = 1'b1;
    end
    check("t4_wait_quiet", bad, 0);
    step();
    check("t4_busy_63", busy, 1);
    check("t4_err_63", timeout_err, 0);
    step();
    check("t4_idle_64", busy, 0);
    check("t4_err_64", timeout_err, 1);
    step();
    check("t4_relaunch", dec_start, 1);
    check("t4_decW", dec_W, 13'h0F1);
    step();
    dec_done = 1'b1;
    step();
    dec_done = 1'b0;
    tick();
    check("t4_idle2", busy, 0);
    check("t4_err_sticky", timeout_err, 1);
    step();

    // en drop mid-RUN, dwell 4
    en = 1'b0;
    push(13'h055, 16'd4);
    en = 1'b1;
    step();
    step();
    dec_done = 1'b1;
    step();
    dec_done = 1'b0;
    step();
    tick(); tick();
    en = 1'b0;
    step();
    check("t5_pwm_gap", pwm_en, 0);
    bad = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (pwm_en || !busy) bad = 1'b1;
    end
    check("t5_gap_frozen", bad, 0);
    en = 1'b1;
    step();
    check("t5_pwm_back", pwm_en, 1);
    tick();
    check("t5_busy_3rd", busy, 1);
    tick();
    check("t5_idle_4th", busy, 0);
    step();

    // Abort mid-RUN with 3 queued; a push offered in the abort cycle is dropped
    en = 1'b0;
    push(13'h1A0, 16'd5);
    push(13'h1A1, 16'd5);
    push(13'h1A2, 16'd5);
    push(13'h1A3, 16'd5);
    en = 1'b1;
    step();
    step();
    dec_done = 1'b1;
    step();
    dec_done = 1'b0;
    step();
    check("t6_count3", fifo_count, 3);
    check("t6_pwm", pwm_en, 1);
    tick();
    abort    = 1'b1;
    wr_valid = 1'b1;
    wr_W     = 13'h1FF;
    wr_dur   = 16'd1;
    #1;
    check("t6_ready_abort", wr_ready, 0);
    step();
    abort    = 1'b0;
    wr_valid = 1'b0;
    check("t6_idle", busy, 0);
    check("t6_flush", fifo_count, 0);
    check("t6_pwm_off", pwm_en, 0);
    check("t6_err_clr", timeout_err, 0);
    check("t6_decW_hold", dec_W, 13'h1A0);
    step();
    step();
    check("t6_no_relaunch", busy, 0);

    // Async reset mid-WAIT
    push(13'h0C3, 16'd2);
    step();
    check("t7_wait", busy, 1);
    check("t7_decW", dec_W, 13'h0C3);
    #2;
    reset = 1'b0;
    #1;
    check("t7_rst_busy", busy, 0);
    check("t7_rst_decW", dec_W, 0);
    check("t7_rst_start", dec_start, 0);
    check("t7_rst_pwm", pwm_en, 0);
    check("t7_rst_count", fifo_count, 0);
    check("t7_rst_ready", wr_ready, 1);
    step();
    reset = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/switch_sequencer.md
Name: switch_sequencer

Overview:
- Schedules a queue of photonic-switch settings onto the shared decoder/PWM datapath.
- Each entry is a 13-bit setting word W plus a dwell time counted in 1 MHz ticks.
- For each entry the block launches a decoder run, waits for the decoder's done, then holds the PWM generator enabled for the programmed dwell. It then advances to the next entry.
- It sits between the host/control logic and the decoder + gen_PWM pair, replacing the single static W input with a sequenced stream.

Parameters:
- DEPTH, 4, number of queued entries (power of 2, ≥2)
- W_WIDTH, 13, setting word width
- DUR_WIDTH, 16, dwell counter width in 1 MHz ticks
- DEC_TIMEOUT, 64, max clk cycles to wait for dec_done before error

Ports:
- clk  input  1  core clock
- reset  input  1  asynchronous, active-low reset
- en  input  1  global enable; gates launching and dwell counting
- abort  input  1  synchronous flush: clear queue, return to IDLE
- wr_valid  input  1  host offers an entry
- wr_ready  output  1  queue can accept (count < DEPTH)
- wr_W  input  W_WIDTH  setting word of offered entry
- wr_dur  input  DUR_WIDTH  dwell of offered entry, in 1 MHz ticks
- tick_1MHz  input  1  one-clk-wide enable pulse from the 1 MHz generator
- dec_start  output  1  one-cycle pulse starting a decoder run
- dec_W  output  W_WIDTH  word presented to decoder; stable from dec_start until next launch
- dec_done  input  1  decoder completion (level or pulse, sampled)
- pwm_en  output  1  enable to PWM generator
- busy  output  1  state != IDLE
- fifo_count  output  $clog2(DEPTH)+1  entries queued (not incl. active)
- timeout_err  output  1  sticky decoder-timeout flag

Behaviour:
- Reset (reset=0, async) values:
  - state=IDLE; FIFO empty, fifo_count=0, wr_ready=1.
  - dec_start=0, dec_W=0, pwm_en=0, busy=0, timeout_err=0.
  - All counters 0.
- Queue:
  - Push on wr_valid&&wr_ready.
  - wr_ready derived from registered count only: when full, no push is accepted, even in a pop cycle.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, LOAD, WAIT, RUN.
- IDLE:
  - If en && count>0 → LOAD.
- LOAD (1 cycle):
  - Pop head into active_W/active_dur; dec_W<=head W; dec_start=1 this cycle only.
  - Clear timeout counter.
  - → WAIT.
- WAIT:
  - dec_done is ignored in the LOAD cycle and sampled from the first WAIT cycle.
  - dec_done=1 and active_dur=0 → IDLE; pwm_en is never asserted for this entry.
  - dec_done=1 and active_dur≠0 → RUN, tick counter=0.
  - Otherwise the timeout counter increments each clk. When it reaches DEC_TIMEOUT-1 without done: set timeout_err, drop the entry, → IDLE.
  - Consequence: with done never asserted, IDLE is reached DEC_TIMEOUT cycles after the LOAD cycle.
  - en is ignored in WAIT.
- RUN:
  - pwm_en = (state==RUN) && en, registered.
  - pwm_en rises the cycle after RUN is entered; a low en drops pwm_en the next cycle.
  - Each tick_1MHz with en=1 increments the tick counter. Ticks while en=0 are not counted, and the count freezes until en returns.
  - On the counted tick where tick counter == active_dur-1, leave RUN:
    - → LOAD if en && count>0 (back-to-back entries, no IDLE cycle);
    - else → IDLE.
  - pwm_en falls the cycle after RUN is left.
  - Dwell = exactly active_dur counted ticks.
- abort (priority over everything except reset):
  - Next cycle: state=IDLE, FIFO emptied, pwm_en=0, dec_start=0, timeout_err=0.
  - A push in the same cycle is dropped; wr_ready is forced 0 while abort=1.
  - dec_W holds its last value.
- timeout_err is cleared only by reset or abort.
- busy=1 in LOAD/WAIT/RUN.

Test Plan:
- Single entry: push (W=0x0A5, dur=3), en=1, dec_done 5 cycles after dec_start → one dec_start pulse with dec_W=0x0A5; pwm_en high from RUN+1 until the 3rd tick_1MHz; then IDLE, busy=0.
- Back-to-back: push 2 entries (dur=2 each) → second dec_start occurs the cycle after the 2nd tick of entry 1; busy never drops; fifo_count goes 2→1→0.
- Full queue: push 5 entries with DEPTH=4 and no pops (en=0) → wr_ready=0 after 4th; 5th not accepted; fifo_count=4.
- Timeout: dec_done held 0 → timeout_err=1 and IDLE exactly DEC_TIMEOUT cycles after the LOAD cycle; pwm_en never asserted; next entry launches normally while flag stays 1.
- en drop mid-RUN: dur=4, deassert en after 2 ticks for 10 ticks → pwm_en=0 during the gap; exactly 2 further ticks after en returns end RUN.
- Abort/reset mid-RUN with 3 queued: abort → next cycle IDLE, fifo_count=0, pwm_en=0. Async reset low mid-WAIT → all outputs at reset values immediately.
